aes_iter_core: RTL

- Iterative AES encryption engine supporting 128-, 192- and 256-bit keys, with the key length selected at runtime.
- Successor to the fully-unrolled fixed-192-bit encryptor: same round datapath, but folded to UNROLL rounds per clock.
- A key is loaded once, expanded word-by-word into an internal schedule, then any number of blocks are encrypted against it.
- Valid/ready handshakes on key, plaintext and ciphertext; sits between the block DMA front-end and the output FIFO.

---
 rtl/aes_iter_core.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/aes_iter_core.sv
// Iterative AES-128/192/256 encryptor: word-serial key expansion, UNROLL rounds per clock, Nr/UNROLL cycle block latency.
// Valid/ready on key, plaintext and ciphertext; one block in flight, output held until out_ready.
module aes_iter_core #(
   parameter int UNROLL = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         key_valid,
   output logic         key_ready,
   input  logic [1:0]   key_len,
   input  logic [255:0] key_in,
   output logic         key_loaded,
   output logic         key_err,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_data
);

   typedef enum logic [2:0] {S_NOKEY, S_KEXP, S_IDLE, S_RUN, S_OUT} state_t;

   state_t       state, state_nxt;
   logic [1:0]   klen;
   logic [5:0]   nk, nw, widx;
   logic [3:0]   nr, rnd, nk_in;
   logic [2:0]   kmod;
   logic [7:0]   rcon;
   logic [127:0] blk, res, rk0, rk_a;
   logic [31:0]  w [60];
   logic [31:0]  temp, wnew;
   logic         key_acc, blk_acc, last_step;

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xtime(x);
      end
      return p;
   endfunction

   // Inverse as a^254 by square-and-multiply, then the AES affine map.
   function automatic logic [7:0] sbox(input logic [7:0] a);
      logic [7:0] sq;
      logic [7:0] inv;
      sq  = a;
      inv = 8'h01;
      for (int k = 1; k < 8; k++) begin
         sq  = gf_mul(sq, sq);
         inv = gf_mul(inv, sq);
      end
      return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
             {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] x);
      return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
   endfunction

   function automatic logic [31:0] mix_col(input logic [7:0] a0, input logic [7:0] a1,
                                           input logic [7:0] a2, input logic [7:0] a3);
      return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
              a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
              a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
              xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
   endfunction

   function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] rk,
                                              input logic last);
      logic [7:0]   b [16];
      logic [7:0]   t [16];
      logic [127:0] o;
      for (int i = 0; i < 16; i++) b[i] = sbox(s[127-8*i -: 8]);
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            t[4*c+r] = b[4*((c+r)%4)+r];
      o = '0;
      for (int c = 0; c < 4; c++) begin
         if (last) o[127-32*c -: 32] = {t[4*c], t[4*c+1], t[4*c+2], t[4*c+3]};
         else      o[127-32*c -: 32] = mix_col(t[4*c], t[4*c+1], t[4*c+2], t[4*c+3]);
      end
      return o ^ rk;
   endfunction

   always_comb begin
      nk = 6'd4;
      nr = 4'd10;
      nw = 6'd44;
      case (klen)
         2'b01: begin nk = 6'd6; nr = 4'd12; nw = 6'd52; end
         2'b10: begin nk = 6'd8; nr = 4'd14; nw = 6'd60; end
         default: ;
      endcase
   end

   assign nk_in   = 4'd4 + {1'b0, key_len, 1'b0};
   assign key_acc = key_valid & key_ready;
   assign blk_acc = in_valid & in_ready;

   // kmod tracks i mod Nk so no divider is needed.
   always_comb begin
      temp = w[widx - 6'd1];
      if (kmod == 3'd0)
         temp = sub_word({temp[23:0], temp[31:24]}) ^ {rcon, 24'h000000};
      else if (nk == 6'd8 && kmod == 3'd4)
         temp = sub_word(temp);
      wnew = w[widx - nk] ^ temp;
   end

   assign rk0  = {w[0], w[1], w[2], w[3]};
   assign rk_a = {w[{rnd, 2'b00}], w[{rnd, 2'b01}], w[{rnd, 2'b10}], w[{rnd, 2'b11}]};

   generate
      if (UNROLL == 2) begin : g_two
         logic [3:0]   rnd_b;
         logic [127:0] mid, rk_b;
         assign rnd_b = rnd + 4'd1;
         assign rk_b  = {w[{rnd_b, 2'b00}], w[{rnd_b, 2'b01}],
                         w[{rnd_b, 2'b10}], w[{rnd_b, 2'b11}]};
         // Nr is even, so the first stage never holds the final round.
         assign mid       = aes_round(blk, rk_a, 1'b0);
         assign res       = aes_round(mid, rk_b, rnd_b == nr);
         assign last_step = (rnd_b == nr);
      end else begin : g_one
         assign res       = aes_round(blk, rk_a, rnd == nr);
         assign last_step = (rnd == nr);
      end
   endgenerate

   always_comb begin
      state_nxt = state;
      key_ready = 1'b0;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         S_NOKEY: begin
            key_ready = 1'b1;
            if (key_valid) state_nxt = (key_len == 2'b11) ? S_NOKEY : S_KEXP;
         end
         S_KEXP: if (widx == nw - 6'd1) state_nxt = S_IDLE;
         S_IDLE: begin
            key_ready = 1'b1;
            // A simultaneous key offer wins; the block waits for the new schedule.
            in_ready  = !key_valid;
            if (key_valid)     state_nxt = (key_len == 2'b11) ? S_NOKEY : S_KEXP;
            else if (in_valid) state_nxt = S_RUN;
         end
         S_RUN: if (last_step) state_nxt = S_OUT;
         S_OUT: begin
            out_valid = 1'b1;
            if (out_ready) state_nxt = S_IDLE;
         end
         default: state_nxt = S_NOKEY;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_NOKEY;
         klen       <= 2'b00;
         widx       <= 6'd0;
         kmod       <= 3'd0;
         rcon       <= 8'h01;
         rnd        <= 4'd0;
         blk        <= '0;
         out_data   <= '0;
         key_loaded <= 1'b0;
         key_err    <= 1'b0;
      end else begin
         state   <= state_nxt;
         key_err <= 1'b0;
         if (key_acc) begin
            key_loaded <= 1'b0;
            key_err    <= (key_len == 2'b11);
            klen       <= key_len;
            widx       <= {2'b00, nk_in};
            kmod       <= 3'd0;
            rcon       <= 8'h01;
         end else if (blk_acc) begin
            blk <= in_data ^ rk0;
            rnd <= 4'd1;
         end
         if (state == S_KEXP) begin
            widx <= widx + 6'd1;
            kmod <= ({3'b000, kmod} == nk - 6'd1) ? 3'd0 : kmod + 3'd1;
            if (kmod == 3'd0) rcon <= xtime(rcon);
            if (widx == nw - 6'd1) key_loaded <= 1'b1;
         end
         if (state == S_RUN) begin
            blk <= res;
            rnd <= rnd + 4'(UNROLL);
            if (last_step) out_data <= res;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (key_acc && key_len != 2'b11) begin
         for (int i = 0; i < 8; i++)
            if (4'(i) < nk_in) w[i] <= key_in[255-32*i -: 32];
      end else if (state == S_KEXP) begin
         w[widx] <= wnew;
      end
   end

endmodule
